// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NREQ valid/ready producers share one FIFO write port in bursts of up to MAX_BURST.
// One idle cycle to arbitrate from IDLE, then zero-bubble handover; fifo_wrfull stalls the granted producer without releasing it.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4,
    parameter int BCW       = 4
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wren,
    output logic [WIDTH-1:0]      fifo_datain,
    input  logic                  fifo_wrfull,
    output logic                  gnt_active,
    output logic [IDW-1:0]        gnt_id,
    output logic [15:0]           xfer_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_gnt;
    logic [IDW-1:0] w_gnt_nxt;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_last_nxt;
    logic [BCW-1:0] r_beat;
    logic [BCW-1:0] w_beat_nxt;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_nxt;

    logic           w_any;
    logic           w_cur_vld;
    logic           w_xfer;
    logic           w_last_beat;
    logic           w_release;
    logic [IDW-1:0] w_pick_idle;
    logic [IDW-1:0] w_pick_rel;

    // Scan starts just after base and ends on base itself, so base is the lowest priority.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                               input logic [IDW-1:0]  base);
        logic [IDW-1:0] sel;
        logic [IDW-1:0] cand;
        logic           found;
        int             pos;
        sel   = base;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            pos  = (int'(base) + k) % NREQ;
            cand = pos[IDW-1:0];
            if (!found && vld[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_any       = |req_valid;
    assign w_pick_idle = rr_pick(req_valid, r_last);
    assign w_pick_rel  = rr_pick(req_valid, r_gnt);
    assign w_cur_vld   = req_valid[r_gnt];
    assign w_xfer      = (r_state == ST_GRANT) && w_cur_vld && !fifo_wrfull;
    assign w_last_beat = (r_beat == BCW'(MAX_BURST - 1));
    // A wrfull stall keeps valid high and blocks xfer, so it can never trigger release.
    assign w_release   = (r_state == ST_GRANT) && ((w_xfer && w_last_beat) || !w_cur_vld);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat;
        w_cnt_nxt   = r_cnt;
        req_ready   = '0;
        fifo_wren   = 1'b0;
        fifo_datain = '0;
        gnt_active  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick_idle;
                    w_last_nxt  = w_pick_idle;
                    w_beat_nxt  = '0;
                end
            end
            ST_GRANT: begin
                gnt_active       = 1'b1;
                fifo_datain      = req_data[r_gnt*WIDTH +: WIDTH];
                req_ready[r_gnt] = !fifo_wrfull;
                fifo_wren        = w_xfer;
                if (w_xfer) begin
                    w_beat_nxt = r_beat + BCW'(1);
                    w_cnt_nxt  = r_cnt + 16'd1;
                end
                if (w_release) begin
                    if (w_any) begin
                        w_gnt_nxt  = w_pick_rel;
                        w_last_nxt = w_pick_rel;
                        w_beat_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= IDW'(NREQ - 1);
            r_beat  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt_id   = r_gnt;
    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a scoreboard of expected writes, and a small FIFO model.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int IDW       = 2;
    localparam int MAX_BURST = 4;
    localparam int BCW       = 4;

    logic                  clk = 1'b0;
    logic                  reset_;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wren;
    logic [WIDTH-1:0]      fifo_datain;
    logic                  fifo_wrfull;
    logic                  gnt_active;
    logic [IDW-1:0]        gnt_id;
    logic [15:0]           xfer_cnt;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .MAX_BURST(MAX_BURST), .BCW(BCW)
    ) dut (
        .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wren(fifo_wren), .fifo_datain(fifo_datain),
        .fifo_wrfull(fifo_wrfull), .gnt_active(gnt_active), .gnt_id(gnt_id),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] rq [0:NREQ-1][$];
    logic [9:0] exp_q[$];
    logic [7:0] mq[$];
    logic [7:0] rd_exp[$];
    logic       force_full = 1'b0;
    logic       model_en = 1'b0;
    logic       rd_all = 1'b0;
    int         rd_pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic put_req(input int r, input logic [7:0] d);
        rq[r].push_back(d);
    endtask

    task automatic put_exp(input int r, input logic [7:0] d);
        exp_q.push_back({r[1:0], d});
    endtask

    task automatic clear_all();
        for (int r = 0; r < NREQ; r++) rq[r].delete();
        exp_q.delete();
        mq.delete();
        rd_exp.delete();
        force_full = 1'b0;
        model_en   = 1'b0;
        rd_all     = 1'b0;
        rd_pending = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        chk("rst_wren", fifo_wren, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_active", gnt_active, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_cnt", xfer_cnt, 0);
        clear_all();
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    // Producers and FIFO model: handshakes sampled mid-cycle, queues advanced just after the edge.
    initial begin
        logic [NREQ-1:0] hs;
        logic            wr_s;
        logic [7:0]      dat_s;
        logic [7:0]      rd_w;
        req_valid   = '0;
        req_data    = '0;
        fifo_wrfull = 1'b0;
        forever begin
            @(negedge clk);
            hs    = req_valid & req_ready;
            wr_s  = fifo_wren;
            dat_s = fifo_datain;
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++)
                if (hs[r] && rq[r].size() > 0) void'(rq[r].pop_front());
            if (model_en) begin
                if (wr_s) mq.push_back(dat_s);
                if ((rd_all || rd_pending > 0) && mq.size() > 0) begin
                    rd_w = mq.pop_front();
                    if (rd_pending > 0) rd_pending--;
                    if (rd_exp.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_order: got %0h want nothing", rd_w);
                    end else begin
                        chk("rd_order", rd_w, rd_exp.pop_front());
                    end
                end
            end
            fifo_wrfull = force_full | (model_en && mq.size() >= 15);
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r]                = rq[r].size() > 0;
                req_data[r*WIDTH +: WIDTH]  = (rq[r].size() > 0) ? rq[r][0] : 8'h00;
            end
        end
    end

    // Scoreboard monitor: every FIFO write must match the next expected (source, word).
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (reset_ === 1'b1 && fifo_wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h want none", fifo_datain);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_src", gnt_id, e[9:8]);
                    chk("wr_data", fifo_datain, e[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ = 1'b0;

        // 1: lone requester, 6 words -> bursts 4+2 with no bubble
        do_reset();
        for (int k = 0; k < 6; k++) begin
            put_req(0, 8'(8'h01 + k));
            put_exp(0, 8'(8'h01 + k));
        end
        @(negedge clk);
        chk("t1_idle_active", gnt_active, 0);
        chk("t1_idle_wren", fifo_wren, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_wren", fifo_wren, 1);
            chk("t1_gnt", gnt_id, 0);
        end
        @(negedge clk);
        chk("t1_tail_active", gnt_active, 1);
        chk("t1_tail_wren", fifo_wren, 0);
        @(negedge clk);
        chk("t1_back_idle", gnt_active, 0);
        chk("t1_cnt", xfer_cnt, 6);
        chk("t1_drain", exp_q.size(), 0);

        // 2: all four valid -> grants 0,1,2,3,0 of 4 beats each
        do_reset();
        for (int k = 0; k < 8; k++) put_req(0, 8'(8'h00 + k));
        for (int r = 1; r < NREQ; r++)
            for (int k = 0; k < 4; k++) put_req(r, 8'(r * 16 + k));
        for (int k = 0; k < 4; k++) put_exp(0, 8'(k));
        for (int k = 0; k < 4; k++) put_exp(1, 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) put_exp(2, 8'(8'h20 + k));
        for (int k = 0; k < 4; k++) put_exp(3, 8'(8'h30 + k));
        for (int k = 4; k < 8; k++) put_exp(0, 8'(k));
        @(negedge clk);
        chk("t2_idle_wren", fifo_wren, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_wren", fifo_wren, 1);
            chk("t2_gnt", gnt_id, (i < 16) ? (i / 4) : 0);
        end
        @(negedge clk);
        chk("t2_tail_wren", fifo_wren, 0);
        @(negedge clk);
        chk("t2_back_idle", gnt_active, 0);
        chk("t2_cnt", xfer_cnt, 20);
        chk("t2_drain", exp_q.size(), 0);

        // 3: req 2 stalled by wrfull for 5 cycles after 2 beats
        do_reset();
        for (int k = 0; k < 4; k++) begin
            put_req(2, 8'(8'h50 + k));
            put_exp(2, 8'(8'h50 + k));
        end
        put_req(3, 8'h66);
        put_exp(3, 8'h66);
        @(negedge clk);
        chk("t3_idle_wren", fifo_wren, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_pre_wren", fifo_wren, 1);
            chk("t3_pre_gnt", gnt_id, 2);
        end
        force_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_wren", fifo_wren, 0);
            chk("t3_stall_ready", req_ready, 0);
            chk("t3_stall_gnt", gnt_id, 2);
        end
        force_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_post_wren", fifo_wren, 1);
            chk("t3_post_gnt", gnt_id, 2);
        end
        @(negedge clk);
        chk("t3_rot_wren", fifo_wren, 1);
        chk("t3_rot_gnt", gnt_id, 3);
        @(negedge clk);
        @(negedge clk);
        chk("t3_cnt", xfer_cnt, 5);
        chk("t3_drain", exp_q.size(), 0);

        // 4: req 1 drops valid after one beat, req 3 takes over without going IDLE
        do_reset();
        put_req(1, 8'hA0);
        put_exp(1, 8'hA0);
        for (int k = 0; k < 3; k++) begin
            put_req(3, 8'(8'hB0 + k));
            put_exp(3, 8'(8'hB0 + k));
        end
        @(negedge clk);
        chk("t4_idle_wren", fifo_wren, 0);
        @(negedge clk);
        chk("t4_first_gnt", gnt_id, 1);
        chk("t4_first_wren", fifo_wren, 1);
        @(negedge clk);
        chk("t4_drop_active", gnt_active, 1);
        chk("t4_drop_wren", fifo_wren, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_next_gnt", gnt_id, 3);
            chk("t4_next_wren", fifo_wren, 1);
        end
        @(negedge clk);
        @(negedge clk);
        chk("t4_cnt", xfer_cnt, 4);
        chk("t4_drain", exp_q.size(), 0);

        // 5: asynchronous reset mid-burst, then lowest valid index wins
        do_reset();
        for (int k = 0; k < 4; k++) begin
            put_req(0, 8'(8'h40 + k));
            put_exp(0, 8'(8'h40 + k));
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3;
        chk("t5_pre_cnt", xfer_cnt, 2);
        chk("t5_pre_wren", fifo_wren, 1);
        reset_ = 1'b0;
        #1;
        chk("t5_async_wren", fifo_wren, 0);
        chk("t5_async_ready", req_ready, 0);
        chk("t5_async_active", gnt_active, 0);
        chk("t5_async_cnt", xfer_cnt, 0);
        clear_all();
        put_req(2, 8'h52);
        put_req(2, 8'h53);
        put_req(3, 8'h63);
        put_exp(2, 8'h52);
        put_exp(2, 8'h53);
        put_exp(3, 8'h63);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        chk("t5_first_active", gnt_active, 1);
        chk("t5_first_gnt", gnt_id, 2);
        chk("t5_first_wren", fifo_wren, 1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("t5_cnt", xfer_cnt, 3);
        chk("t5_drain", exp_q.size(), 0);

        // 6: 16-entry FIFO model, wrfull at 15 stored, no reads then 3 reads then drain
        do_reset();
        model_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            put_req(0, 8'(8'h80 + k));
            put_exp(0, 8'(8'h80 + k));
            rd_exp.push_back(8'(8'h80 + k));
        end
        for (int i = 0; i < 30; i++) @(negedge clk);
        chk("t6_full_cnt", xfer_cnt, 15);
        chk("t6_full_flag", fifo_wrfull, 1);
        chk("t6_full_wren", fifo_wren, 0);
        chk("t6_full_ready", req_ready, 0);
        chk("t6_full_gnt", gnt_id, 0);
        rd_pending = 3;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("t6_after_rd_cnt", xfer_cnt, 18);
        chk("t6_after_rd_wren", fifo_wren, 0);
        rd_all = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() > 0 || rd_exp.size() > 0); i++) @(negedge clk);
        chk("t6_drain", exp_q.size() + rd_exp.size(), 0);
        chk("t6_cnt", xfer_cnt, 20);
        rd_all   = 1'b0;
        model_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
